regfile_wr_arbiter: RTL
=======================

# regfile_wr_arbiter

Arbiter and scoreboard for the single write port of the 32-entry, 32-bit register file. It shares that port between up to NREQ result producers: ALU writeback, load return, and multiply/divide completion. It drives the register file's write_register / write_data / regwrite_ctrl inputs from a registered output stage, and keeps a per-register pending-write bitmask so the hazard/stall logic can hold dependent instructions.

## Interface
- NREQ, 3, number of requesters; index 0 = ALU, 1 = load, 2 = mul/div
- DW, 32, data width
- AW, 5, register index width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  per-requester write request
- req_reg  in  NREQ*AW  destination register; requester i occupies bits [i*AW +: AW]
- req_data  in  NREQ*DW  write data; requester i occupies bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant; a request is accepted on a cycle where valid and ready are both high
- rsv_valid  in  1  reserve a destination at instruction issue
- rsv_reg  in  AW  register index to reserve
- pending_o  out  32  bit r set = a write to register r is outstanding
- wr_en_o  out  1  to regfile regwrite_ctrl
- wr_reg_o  out  AW  to regfile write_register
- wr_data_o  out  DW  to regfile write_data

## Operation
- Handshake is valid/ready per requester.
  - Once asserted, req_valid[i] and its reg/data fields stay stable until accepted.
  - req_ready is combinational from req_valid and the round-robin pointer. It never depends on req_ready itself.
- Arbitration is round-robin with a pointer ptr in the range 0..NREQ-1.
  - Search starts at ptr and wraps modulo NREQ. The first valid requester is granted.
  - At most one grant per cycle.
  - On a grant to index g, ptr becomes (g+1) mod NREQ. With no grant, ptr holds.
- Output stage, on the edge following an acceptance:
  - wr_reg_o and wr_data_o load the granted request's fields.
  - wr_en_o = 1, except when the granted reg is 0: then wr_en_o = 0. The request is still consumed, because $zero is never written.
- With no acceptance, wr_en_o = 0 and wr_reg_o / wr_data_o hold their last values.
- Scoreboard, updated on each edge:
  - Clear: an acceptance to register r (r≠0) clears pending bit r.
  - Set: rsv_valid with rsv_reg = r (r≠0) sets pending bit r.
  - Same register in the same cycle: set wins, so the newer reservation stays outstanding.
  - Reservations of register 0 are ignored, so pending_o[0] is always 0.
  - A reservation of an already-pending register leaves the bit at 1; no counting.
  - An acceptance to a non-pending register is legal and leaves the bit at 0.
- Reset (rst high at an edge):
  - ptr = 0, pending_o = 0, wr_en_o = 0, wr_reg_o = 0, wr_data_o = 0.
  - Requests presented in the reset cycle are ignored and not accepted: req_ready = 0 while rst = 1.
  - An acceptance in flight is discarded. wr_en_o is 0 in the cycle after reset, even if a grant occurred the cycle before.

## Timing
- Request valid in cycle N and granted in N → accepted in N.
  - wr_en_o, wr_reg_o and wr_data_o are valid in N+1, for exactly one cycle.
  - The pending bit is low from N+1, coincident with wr_en_o.
  - The regfile's write-through forwarding makes the value readable in N+1; it is in storage from N+2.
- Sustained throughput: one write per cycle.
- Worst-case wait for a continuously-valid requester: NREQ-1 cycles.
- rsv_valid in cycle N → pending bit visible in N+1.
- No combinational path from req_* to wr_*_o or pending_o.

## Test plan
- Reset, then single request: req_valid = 3'b001, reg = 5, data = 0xDEADBEEF in cycle 1.
  - Expect req_ready = 3'b001 in cycle 1.
  - Expect wr_en_o = 1, wr_reg_o = 5, wr_data_o = 0xDEADBEEF in cycle 2 only.
- All three requesters held valid from ptr = 0, with regs 1, 2, 3.
  - Expect grants 001, 010, 100 in consecutive cycles.
  - Expect writes to r1, r2, r3 in the cycles after.
  - Re-asserting all three afterwards must start again at 001.
- Fairness: requester 0 valid every cycle, requester 2 valid from cycle 0.
  - Requester 2 is granted no later than cycle 2.
  - Grants alternate 0/2 thereafter.
- Scoreboard:
  - rsv r7 in cycle 1 → pending_o[7] = 1 in cycle 2.
  - Load writes r7, accepted in cycle 4 → pending_o[7] = 0 and wr_en_o = 1 in cycle 5.
  - Simultaneous rsv r9 and acceptance to r9 → pending_o[9] = 1 afterwards.
- $zero:
  - Request to reg 0 with data 0x1234 → accepted (ready = 1), but wr_en_o = 0 next cycle.
  - rsv_reg = 0 → pending_o[0] stays 0.
- Reset mid-operation: grant in cycle N and rst = 1 in cycle N+1.
  - Expect wr_en_o = 0 and pending_o = 0 after that edge.
  - Expect ptr back at 0, shown by the first grant going to requester 0 when all are valid.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a registered
// output stage and a per-register pending-write scoreboard for hazard detection.
module regfile_wr_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_reg,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_reg,
  output logic [31:0]          pending_o,
  output logic                 wr_en_o,
  output logic [AW-1:0]        wr_reg_o,
  output logic [DW-1:0]        wr_data_o
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gnt_idx;
  logic          gnt_any;
  logic [AW-1:0] sel_reg;
  logic [DW-1:0] sel_data;
  logic [31:0]   pending_q, pending_d;
  logic          wr_en_q;
  logic [AW-1:0] wr_reg_q;
  logic [DW-1:0] wr_data_q;

  // Search from ptr, wrapping modulo NREQ; nothing is granted while in reset.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (!rst) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = 32'(ptr_q) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!gnt_any && req_valid[idx[PW-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = idx[PW-1:0];
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_reg  = req_reg[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + PW'(1);
    end
  end

  // Clear before set so a same-cycle reservation of the written register survives.
  always_comb begin
    pending_d = pending_q;
    if (gnt_any && (sel_reg != '0)) pending_d[sel_reg] = 1'b0;
    if (rsv_valid && (rsv_reg != '0)) pending_d[rsv_reg] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      pending_q <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      // Writes to $zero are consumed but never reach the register file.
      wr_en_q   <= gnt_any && (sel_reg != '0);
      if (gnt_any) begin
        wr_reg_q  <= sel_reg;
        wr_data_q <= sel_data;
      end
    end
  end

  assign pending_o = pending_q;
  assign wr_en_o   = wr_en_q;
  assign wr_reg_o  = wr_reg_q;
  assign wr_data_o = wr_data_q;

endmodule
